mips_controller: RTL and testbench

MIPS_CONTROLLER -- requirements
Module: mips_controller

---
 rtl/mips_controller.sv | 192 +++++++++++++++++++
 tb/tb_mips_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multicycle MIPS control FSM (byte-wide fetch, lb/sb/R-type/beq/j/addi)
//
// Purpose: Moore control unit for a multicycle MIPS datapath whose instruction
// register is loaded one byte per cycle. Every state drives the datapath
// selects and enables below; outputs are registered from the next state, so
// they change together with the state register.
//
// Ports:
//   clk        - single clock
//   reset      - asynchronous active-high reset, forces FETCH1 and its outputs
//   op, funct  - instr[31:26] and instr[5:0] from the instruction register
//   zero       - ALU zero flag, gates pcen combinationally in BEQEX
//   memwrite   - byte store strobe
//   pcen       - PC register enable
//   iord       - memory address select (0 pc, 1 aluout)
//   alusrcA    - ALU A select (0 pc, 1 A register)
//   alusrcB    - ALU B select (00 wd reg, 01 const 1, 10 signext imm, 11 imm x4)
//   pcsrc      - next-PC select (00 aluresult, 01 aluout, 10 jump target)
//   irwrite    - one-hot instruction register byte enable
//   regwrite   - register file write enable
//   regdst     - write address select (0 rt, 1 rd)
//   memtoreg   - write data select (0 aluout, 1 data register)
//   alucontrol - ALU operation

module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       pcen,
  output logic       iord,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [3:0] irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } state_t;

  // beq marks BEQEX so pcen can follow zero within the cycle
  typedef struct packed {
    logic       memwrite;
    logic       pcen;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [2:0] alucontrol;
    logic       beq;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.pcen    = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = 4'b0001 << s;  // FETCH1..4 encode as 0..3
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      LBRD:    c.iord = 1'b1;
      LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      SBWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca    = 1'b1;
        c.alucontrol = funct_alu(f);
      end
      RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca    = 1'b1;
        c.alucontrol = ALU_SUB;
        c.pcsrc      = 2'b01;
        c.beq        = 1'b1;
      end
      JEX: begin
        c.pcsrc = 2'b10;
        c.pcen  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWR:  c.regwrite = 1'b1;
      default: c = c;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = FETCH1;
    case (state)
      FETCH1:  state_next = FETCH2;
      FETCH2:  state_next = FETCH3;
      FETCH3:  state_next = FETCH4;
      FETCH4:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_J:         state_next = JEX;
          OP_ADDI:      state_next = ADDIEX;
          default:      state_next = FETCH1;
        endcase
      end
      MEMADR:  state_next = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    state_next = LBWR;
      RTYPEEX: state_next = RTYPEWR;
      ADDIEX:  state_next = ADDIWR;
      default: state_next = FETCH1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH1;
      ctrl  <= decode(FETCH1, 6'b000000);
    end else begin
      state <= state_next;
      ctrl  <= decode(state_next, funct);
    end
  end

  assign memwrite   = ctrl.memwrite;
  assign pcen       = ctrl.pcen | (ctrl.beq & zero);
  assign iord       = ctrl.iord;
  assign alusrcA    = ctrl.alusrca;
  assign alusrcB    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign irwrite    = ctrl.irwrite;
  assign regwrite   = ctrl.regwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign alucontrol = ctrl.alucontrol;

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - randomized self-checking bench for mips_controller

module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       memwrite, pcen, iord, alusrcA, regwrite, regdst, memtoreg;
  logic [1:0] alusrcB, pcsrc;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .pcen(pcen), .iord(iord), .alusrcA(alusrcA),
    .alusrcB(alusrcB), .pcsrc(pcsrc), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // {memwrite,pcen,iord,alusrcA,alusrcB,pcsrc,irwrite,regwrite,regdst,memtoreg,alucontrol}
  wire [17:0] obs = {memwrite, pcen, iord, alusrcA, alusrcB, pcsrc, irwrite,
                     regwrite, regdst, memtoreg, alucontrol};

  localparam logic [17:0] FETCH1_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0001,
                                        1'b0, 1'b0, 1'b0, 3'b010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b001000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
      default:   return 5;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs in cycle 'cyc' (0 = first fetch cycle) of an instruction.
  function automatic logic [17:0] expect_out(input int cyc, input logic [5:0] o,
                                             input logic [5:0] f, input logic z);
    logic mw, pc, io, sa, rw, rd, mt;
    logic [1:0] sb, ps;
    logic [3:0] ir;
    logic [3:0] one;
    logic [2:0] ac;
    mw = 0; pc = 0; io = 0; sa = 0; rw = 0; rd = 0; mt = 0;
    sb = 2'b00; ps = 2'b00; ir = 4'b0000; ac = 3'b010; one = 4'b0001;
    if (cyc < 4) begin
      pc = 1; sb = 2'b01; ir = one << cyc;
    end else if (cyc == 4) begin
      sb = 2'b11;
    end else begin
      case (o)
        6'b100000: begin
          if (cyc == 5) begin sa = 1; sb = 2'b10; end
          if (cyc == 6) io = 1;
          if (cyc == 7) begin rw = 1; mt = 1; end
        end
        6'b101000: begin
          if (cyc == 5) begin sa = 1; sb = 2'b10; end
          if (cyc == 6) begin io = 1; mw = 1; end
        end
        6'b000000: begin
          if (cyc == 5) begin sa = 1; ac = alu_of(f); end
          if (cyc == 6) begin rw = 1; rd = 1; end
        end
        6'b000100: begin
          sa = 1; ac = 3'b110; ps = 2'b01; pc = z;
        end
        6'b000010: begin
          ps = 2'b10; pc = 1;
        end
        6'b001000: begin
          if (cyc == 5) begin sa = 1; sb = 2'b10; end
          if (cyc == 6) rw = 1;
        end
        default: ;
      endcase
    end
    return {mw, pc, io, sa, sb, ps, ir, rw, rd, mt, ac};
  endfunction

  // Runs cycles 0..n-1 of an instruction; entered and left just after a negedge.
  task automatic run_cycles(input logic [5:0] o, input logic [5:0] f, input int n);
    op = o;
    funct = f;
    for (int c = 0; c < n; c++) begin
      zero = 1'($urandom);
      #1;
      check($sformatf("op%02h_f%02h_c%0d", o, f, c), 32'(obs), 32'(expect_out(c, o, f, zero)));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_async"}, 32'(obs), 32'(FETCH1_VEC));
    check({tag, "_nostore"}, 32'({regwrite, memwrite}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"}, 32'(obs), 32'(FETCH1_VEC));
    reset = 1'b0;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7];
    ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] fs [5];
    fs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 3) == 0) return 6'($urandom);
    return fs[$urandom_range(0, 4)];
  endfunction

  initial begin
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset_state", 32'(obs), 32'(FETCH1_VEC));
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(obs), 32'(FETCH1_VEC));
    reset = 1'b0;

    // Directed: lb, slt, beq both ways, sb, unsupported op
    run_cycles(6'b100000, 6'b000000, 8);
    run_cycles(6'b000000, 6'b101010, 7);
    op = 6'b000100;
    run_cycles(6'b000100, 6'b000000, 5);
    zero = 1'b0; #1;
    check("beq_z0_pcen", 32'(pcen), 32'd0);
    zero = 1'b1; #1;
    check("beq_z1_pcen", 32'({pcen, pcsrc}), 32'b101);
    @(posedge clk);
    @(negedge clk);
    run_cycles(6'b101000, 6'b000000, 7);
    run_cycles(6'b111111, 6'b000000, 5);

    // Reset in the middle of SBWR
    run_cycles(6'b101000, 6'b000000, 6);
    #1;
    check("sbwr_memwrite", 32'({memwrite, iord}), 32'b11);
    reset_pulse("rst_sbwr");
    run_cycles(6'b001000, 6'b000000, 7);

    // Random instruction stream with occasional mid-instruction resets
    for (int i = 0; i < 80; i++) begin
      logic [5:0] o;
      logic [5:0] f;
      o = pick_op();
      f = pick_funct();
      if ($urandom_range(0, 9) == 0) begin
        run_cycles(o, f, $urandom_range(1, instr_len(o) - 1));
        reset_pulse($sformatf("rst_rand%0d", i));
      end else begin
        run_cycles(o, f, instr_len(o));
      end
    end

    #1;
    check("final_fetch1", 32'(obs), 32'(FETCH1_VEC));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
